// File: rtl/qpu_exu_msrfile_if.sv
// qpu_exu_msrfile_if: single-qubit history read port (request handshake plus registered response).
interface qpu_exu_msrfile_if #(
   parameter int QIDX_W     = 4,
   parameter int HIST_IDX_W = 2
);
   logic                  rd_req_vld;
   logic                  rd_req_rdy;
   logic [QIDX_W-1:0]     rd_qubit_idx;
   logic [HIST_IDX_W-1:0] rd_hist_sel;
   logic                  rd_rsp_vld;
   logic                  rd_rsp_data;
   logic                  rd_rsp_err;
   modport master (
      output rd_req_vld, rd_qubit_idx, rd_hist_sel,
      input  rd_req_rdy, rd_rsp_vld, rd_rsp_data, rd_rsp_err
   );
   modport slave (
      input  rd_req_vld, rd_qubit_idx, rd_hist_sel,
      output rd_req_rdy, rd_rsp_vld, rd_rsp_data, rd_rsp_err
   );
endinterface

// File: rtl/qpu_exu_msrfile.sv
// qpu_exu_msrfile: per-qubit circular measurement history with pending tracking, feedback flags and a read port.
module qpu_exu_msrfile #(
   parameter int QUBIT_NUM  = 12,
   parameter int QIDX_W     = 4,
   parameter int HIST_DEPTH = 4,
   parameter int HIST_IDX_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 meas_issue_vld,
   input  logic [QUBIT_NUM-1:0] meas_issue_list,
   input  logic                 mcu_measure_i_wen,
   input  logic [QUBIT_NUM-1:0] mcu_measure_i_list,
   input  logic [QUBIT_NUM-1:0] mcu_measure_i_data,
   input  logic                 hist_clr,
   qpu_exu_msrfile_if.slave     rd,
   output logic [QUBIT_NUM-1:0] qubit_measure_pend,
   output logic [QUBIT_NUM-1:0] qubit_measure_zero,
   output logic [QUBIT_NUM-1:0] qubit_measure_one,
   output logic [QUBIT_NUM-1:0] qubit_measure_equ
);
   localparam logic [HIST_IDX_W:0] FULL = (HIST_IDX_W+1)'(HIST_DEPTH);
   localparam logic [QIDX_W:0]     QN   = (QIDX_W+1)'(QUBIT_NUM);
   logic [HIST_DEPTH-1:0] hist [QUBIT_NUM];
   logic [HIST_IDX_W-1:0] wptr [QUBIT_NUM];
   logic [HIST_IDX_W:0]   cnt  [QUBIT_NUM];
   logic [QUBIT_NUM-1:0]  pend;
   logic [QUBIT_NUM-1:0]  wr;
   assign wr = mcu_measure_i_wen ? mcu_measure_i_list : '0;
   // A same-cycle issue re-arms pend after the write clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         for (int k = 0; k < QUBIT_NUM; k++) begin
            hist[k] <= '0;
            wptr[k] <= '0;
            cnt[k]  <= '0;
         end
      end else if (hist_clr) begin
         pend <= '0;
         for (int k = 0; k < QUBIT_NUM; k++) begin
            hist[k] <= '0;
            wptr[k] <= '0;
            cnt[k]  <= '0;
         end
      end else begin
         pend <= (meas_issue_vld ? meas_issue_list : '0) | (pend & ~wr);
         for (int k = 0; k < QUBIT_NUM; k++) begin
            if (wr[k]) begin
               hist[k][wptr[k]] <= mcu_measure_i_data[k];
               wptr[k]          <= wptr[k] + 1'b1;
               cnt[k]           <= cnt[k] == FULL ? cnt[k] : cnt[k] + 1'b1;
            end
         end
      end
   end
   assign qubit_measure_pend = pend;
   for (genvar g = 0; g < QUBIT_NUM; g++) begin : g_flag
      logic [HIST_IDX_W-1:0] lp, pp;
      logic                  live;
      assign lp   = wptr[g] - HIST_IDX_W'(1);
      assign pp   = wptr[g] - HIST_IDX_W'(2);
      assign live = ~pend[g] & (cnt[g] != '0);
      assign qubit_measure_zero[g] = live & ~hist[g][lp];
      assign qubit_measure_one[g]  = live & hist[g][lp];
      assign qubit_measure_equ[g]  = ~pend[g] & (cnt[g] >= (HIST_IDX_W+1)'(2)) & (hist[g][lp] == hist[g][pp]);
   end
   logic                  idx_ok, sel_ok, rdy, acc;
   logic [QIDX_W-1:0]     qi;
   logic [HIST_IDX_W-1:0] rp;
   always_comb begin
      idx_ok = {1'b0, rd.rd_qubit_idx} < QN;
      qi     = idx_ok ? rd.rd_qubit_idx : '0;
      sel_ok = {1'b0, rd.rd_hist_sel} < cnt[qi];
      rp     = wptr[qi] - HIST_IDX_W'(1) - rd.rd_hist_sel;
      rdy    = ~idx_ok | ~pend[qi];
      acc    = rd.rd_req_vld & rdy & ~hist_clr;
   end
   assign rd.rd_req_rdy = rdy;
   // Response samples the pre-write history of the accept cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd.rd_rsp_vld  <= 1'b0;
         rd.rd_rsp_err  <= 1'b0;
         rd.rd_rsp_data <= 1'b0;
      end else begin
         rd.rd_rsp_vld  <= acc;
         rd.rd_rsp_err  <= acc & ~(idx_ok & sel_ok);
         rd.rd_rsp_data <= acc & idx_ok & sel_ok & hist[qi][rp];
      end
   end
endmodule
